// File: rtl/mm2s_rd_scheduler.sv
// mm2s_rd_scheduler: credit-aware AXI read-address scheduler for the MM2S
// read datapath. Each channel takes one command (byte address and beat
// count). The command is cut into INCR bursts that do not cross a 4 KB
// boundary. Channels share a single AR channel through round-robin
// arbitration, and ARID is the channel index. A burst is granted only when
// the channel's downstream FIFO has credit for every beat of the burst.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/ready/addr/beats per-channel command handshake
//   m_axi_ar*                  AXI read-address channel (registered)
//   credit_ret                 per-channel one-beat credit return pulses
//   ch_busy                    channel still holds unissued beats
//   all_idle                   nothing busy, no AR pending, all credits full
//   credit_err                 sticky credit-overflow flags
//   stat_bursts, stat_stall_cycles  only with MM2S_RD_SCHED_STATS_EN

// Per-channel command state: burst splitting and credit accounting.
module mm2s_rd_sched_ch #(
  parameter int ADDR_WIDTH = 64,
  parameter int ARSIZE     = 6,
  parameter int LEN_WIDTH  = 58,
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 512,
  parameter int CW         = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_beats,
  input  logic                  load,
  input  logic                  credit_ret,
  output logic                  active,
  output logic                  eligible,
  output logic [LEN_WIDTH-1:0]  addr_beat,
  output logic [8:0]            burst,
  output logic                  credit_full,
  output logic                  credit_err
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state, state_nx;
  logic [LEN_WIDTH-1:0] remain, remain_nx, addr_nx, room, blen;
  logic [CW-1:0]        credit, credit_nx;
  logic                 err_nx;

  if (ARSIZE > 0) begin : g_lsb
    logic lsb_unused;
    assign lsb_unused = ^cmd_addr[ARSIZE-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_beat  <= '0;
      remain     <= '0;
      credit     <= CW'(FIFO_DEPTH);
      credit_err <= 1'b0;
    end else begin
      state      <= state_nx;
      addr_beat  <= addr_nx;
      remain     <= remain_nx;
      credit     <= credit_nx;
      credit_err <= err_nx;
    end
  end

  always_comb begin
    // Beats left before the next 4 KB boundary, then clip to what remains.
    room        = LEN_WIDTH'(BURST_LEN) - (addr_beat & LEN_WIDTH'(BURST_LEN - 1));
    blen        = (remain < room) ? remain : room;
    burst       = blen[8:0];
    active      = (state == ACTIVE);
    cmd_ready   = (state == IDLE);
    credit_full = (credit == CW'(FIFO_DEPTH));
    eligible    = active && (32'(credit) >= 32'(burst));
    state_nx    = state;
    addr_nx     = addr_beat;
    remain_nx   = remain;
    credit_nx   = credit;
    err_nx      = credit_err;
    case (state)
      IDLE: if (cmd_valid) begin
        addr_nx   = cmd_addr[ADDR_WIDTH-1:ARSIZE];
        remain_nx = cmd_beats;
        if (cmd_beats != '0) state_nx = ACTIVE;
      end
      ACTIVE: if (load) begin
        addr_nx   = addr_beat + blen;
        remain_nx = remain - blen;
        if (remain == blen) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (load) credit_nx = credit - CW'(burst);
    // A return with a full counter means the FIFO popped a beat it never had.
    if (credit_ret) begin
      if (credit_full) err_nx = 1'b1;
      else             credit_nx = credit_nx + CW'(1);
    end
  end
endmodule

module mm2s_rd_scheduler #(
  parameter  int MEM_WIDTH  = 512,
  parameter  int ADDR_WIDTH = 64,
  parameter  int N_CHANNELS = 16,
  parameter  int FIFO_DEPTH = 512,
  localparam int ARSIZE     = $clog2(MEM_WIDTH / 8),
  localparam int BURST_LEN  = ((4096 / (MEM_WIDTH / 8)) > 256) ? 256 : 4096 / (MEM_WIDTH / 8),
  localparam int LEN_WIDTH  = ADDR_WIDTH - ARSIZE,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_CHANNELS-1:0]                 cmd_valid,
  output logic [N_CHANNELS-1:0]                 cmd_ready,
  input  logic [N_CHANNELS-1:0][ADDR_WIDTH-1:0] cmd_addr,
  input  logic [N_CHANNELS-1:0][LEN_WIDTH-1:0]  cmd_beats,
  output logic [ADDR_WIDTH-1:0]                 m_axi_araddr,
  output logic [7:0]                            m_axi_arlen,
  output logic [2:0]                            m_axi_arsize,
  output logic [1:0]                            m_axi_arburst,
  output logic [3:0]                            m_axi_arcache,
  output logic [2:0]                            m_axi_arprot,
  output logic [3:0]                            m_axi_arid,
  output logic                                  m_axi_arvalid,
  input  logic                                  m_axi_arready,
  input  logic [N_CHANNELS-1:0]                 credit_ret,
  output logic [N_CHANNELS-1:0]                 ch_busy,
  output logic                                  all_idle,
  output logic [N_CHANNELS-1:0]                 credit_err
`ifdef MM2S_RD_SCHED_STATS_EN
  ,
  output logic [N_CHANNELS-1:0][31:0]           stat_bursts,
  output logic [31:0]                           stat_stall_cycles
`endif
);
  localparam int PW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  logic [N_CHANNELS-1:0]                active, eligible, credit_full, load;
  logic [N_CHANNELS-1:0][LEN_WIDTH-1:0] addr_beat;
  logic [N_CHANNELS-1:0][8:0]           burst;
  logic [PW-1:0]                        rr, grant;
  logic                                 grant_vld, can_load;

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    mm2s_rd_sched_ch #(
      .ADDR_WIDTH(ADDR_WIDTH), .ARSIZE(ARSIZE), .LEN_WIDTH(LEN_WIDTH),
      .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .CW(CW)
    ) u_ch (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[i]), .cmd_ready(cmd_ready[i]),
      .cmd_addr(cmd_addr[i]), .cmd_beats(cmd_beats[i]),
      .load(load[i]), .credit_ret(credit_ret[i]),
      .active(active[i]), .eligible(eligible[i]),
      .addr_beat(addr_beat[i]), .burst(burst[i]),
      .credit_full(credit_full[i]), .credit_err(credit_err[i])
    );
  end

  // The AR slot can take a new burst when empty or draining this cycle;
  // arready only affects the next register value, never arvalid directly.
  assign can_load = !m_axi_arvalid || m_axi_arready;

  always_comb begin : arb
    logic [PW-1:0] idx;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      idx = PW'((int'(rr) + k) % N_CHANNELS);
      if (!grant_vld && eligible[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    load = '0;
    if (can_load && grant_vld) load[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arid    <= '0;
      rr            <= '0;
    end else if (can_load) begin
      m_axi_arvalid <= grant_vld;
      if (grant_vld) begin
        m_axi_araddr <= ADDR_WIDTH'(addr_beat[grant]) << ARSIZE;
        m_axi_arlen  <= 8'(burst[grant] - 9'd1);
        m_axi_arid   <= 4'(grant);
        rr           <= (grant == PW'(N_CHANNELS - 1)) ? '0 : grant + PW'(1);
      end
    end
  end

  assign m_axi_arsize  = 3'(ARSIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign ch_busy       = active;
  assign all_idle      = !(|active) && !m_axi_arvalid && (&credit_full);

`ifdef MM2S_RD_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bursts       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (m_axi_arvalid && m_axi_arready)
        stat_bursts[m_axi_arid[PW-1:0]] <= stat_bursts[m_axi_arid[PW-1:0]] + 32'd1;
      if (|active && !(|eligible))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mm2s_rd_scheduler.sv
// Self-checking bench for mm2s_rd_scheduler (default build, stats disabled).
// The reference model splits every accepted command into its 4 KB-bounded
// burst list. Observed AR handshakes are matched per channel against that
// list. Directed steps cover ordering, stalls, hold and reset, followed by
// a randomized phase.
module tb_mm2s_rd_scheduler;
  localparam int AW = 32;
  localparam int N  = 8;
  localparam int FD = 256;
  localparam int LW = AW - 6;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N-1:0]          cmd_valid = '0, cmd_ready;
  logic [N-1:0][AW-1:0]  cmd_addr = '0;
  logic [N-1:0][LW-1:0]  cmd_beats = '0;
  logic [AW-1:0]         araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize, arprot;
  logic [1:0]            arburst;
  logic [3:0]            arcache, arid;
  logic                  arvalid, arready = 1'b0;
  logic [N-1:0]          credit_ret = '0, ch_busy, credit_err;
  logic                  all_idle;

  mm2s_rd_scheduler #(.MEM_WIDTH(512), .ADDR_WIDTH(AW), .N_CHANNELS(N), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
    .m_axi_arid(arid), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .credit_ret(credit_ret), .ch_busy(ch_busy), .all_idle(all_idle),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; int id; int cyc; } burst_t;

  int       checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  burst_t   exp_q[$];
  burst_t   log_q[$];
  int       owed[N];
  logic [N-1:0] acc = '0;
  logic     auto_ret = 1'b0, rand_ardy = 1'b0;
  int       ret_pct = 100;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: cut a command into bursts, each ending at or before a 4 KB line.
  task automatic model_cmd(int ch, logic [31:0] a, int n);
    logic [31:0] p;
    int b, room;
    p = a & ~32'h3f;
    while (n > 0) begin
      room = (4096 - int'(p % 4096)) / 64;
      b = (n < room) ? n : room;
      exp_q.push_back('{p, 8'(b - 1), ch, 0});
      p += 32'(b * 64);
      n -= b;
    end
  endtask

  function automatic int owed_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += owed[i];
    return s;
  endfunction

  task automatic sample();
    int k;
    k = -1;
    if (arvalid && arready) begin
      for (int j = 0; j < exp_q.size(); j++)
        if (k < 0 && exp_q[j].id == int'(arid)) k = j;
      chk("ar_expected", 64'(k >= 0), 64'(1));
      if (k >= 0) begin
        chk("araddr", 64'(araddr), 64'(exp_q[k].addr));
        chk("arlen", 64'(arlen), 64'(exp_q[k].len));
        exp_q.delete(k);
      end
      log_q.push_back('{araddr, arlen, int'(arid), cyc});
      owed[arid] += int'(arlen) + 1;
      chk("outstanding_le_depth", 64'(owed[arid] <= FD), 64'(1));
    end
    for (int i = 0; i < N; i++)
      if (cmd_valid[i] && cmd_ready[i]) begin
        model_cmd(i, cmd_addr[i], int'(cmd_beats[i]));
        acc[i] = 1'b1;
        acc_cyc = cyc;
      end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin cmd_valid[i] = 1'b0; acc[i] = 1'b0; end
    credit_ret = '0;
    if (auto_ret)
      for (int i = 0; i < N; i++)
        if (owed[i] > 0 && $urandom_range(99) < ret_pct) begin
          credit_ret[i] = 1'b1;
          owed[i]--;
        end
    if (rand_ardy) arready = ($urandom_range(99) < 70);
  endtask

  task automatic issue(int ch, logic [31:0] a, int n);
    cmd_valid[ch] = 1'b1;
    cmd_addr[ch]  = a;
    cmd_beats[ch] = LW'(n);
  endtask

  task automatic wait_log(string tag, int n, int bound);
    int c = 0;
    while (log_q.size() < n && c < bound) begin step(); c++; end
    chk(tag, 64'(log_q.size() >= n), 64'(1));
  endtask

  task automatic drain(string tag);
    int c = 0;
    rand_ardy = 1'b0; arready = 1'b1; auto_ret = 1'b1; ret_pct = 100;
    while ((exp_q.size() != 0 || owed_total() != 0 || ch_busy != '0 || arvalid) && c < 4000) begin
      step(); c++;
    end
    chk(tag, 64'(c < 4000), 64'(1));
    step();
    chk({tag, "_all_idle"}, 64'(all_idle), 64'(1));
    auto_ret = 1'b0;
  endtask

  // Called just after a posedge; asserts reset mid-cycle, away from any edge.
  task automatic do_reset();
    #3 rst_n = 1'b0;
    cmd_valid = '0; credit_ret = '0; arready = 1'b0; acc = '0;
    rand_ardy = 1'b0; auto_ret = 1'b0;
    exp_q.delete(); log_q.delete();
    for (int i = 0; i < N; i++) owed[i] = 0;
    #1;
    chk("rst_arvalid", 64'(arvalid), 64'(0));
    chk("rst_araddr", 64'(araddr), 64'(0));
    chk("rst_arlen_arid", 64'({arlen, arid}), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(8'hff));
    chk("rst_busy_err", 64'({ch_busy, credit_err}), 64'(0));
    chk("rst_all_idle", 64'(all_idle), 64'(1));
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    int r;
    for (int i = 0; i < N; i++) owed[i] = 0;
    @(posedge clk); #1;
    do_reset();
    chk("arsize", 64'(arsize), 64'(6));
    chk("arburst", 64'(arburst), 64'(1));
    chk("arcache", 64'(arcache), 64'(3));
    chk("arprot", 64'(arprot), 64'(0));

    // 200 beats from 0: four back-to-back bursts split at 4 KB lines.
    arready = 1'b1;
    issue(0, 32'h0, 200);
    step();
    r = acc_cyc;
    wait_log("t1_bursts", 4, 20);
    if (log_q.size() >= 4) begin
      chk("t1_latency", 64'(log_q[0].cyc - r), 64'(2));
      for (int j = 1; j < 4; j++) chk("t1_consecutive", 64'(log_q[j].cyc - log_q[0].cyc), 64'(j));
      chk("t1_last_addr", 64'(log_q[3].addr), 64'(32'h3000));
      chk("t1_last_len", 64'(log_q[3].len), 64'(7));
      chk("t1_arid", 64'(log_q[2].id), 64'(0));
    end
    step();
    chk("t1_cmd_ready", 64'(cmd_ready[0]), 64'(1));
    chk("t1_not_idle_credit", 64'(all_idle), 64'(0));
    drain("t1_drain");

    // Command starting one beat before a 4 KB line.
    log_q.delete();
    issue(1, 32'h0FC0, 10);
    step();
    wait_log("t2_bursts", 2, 20);
    if (log_q.size() >= 2) begin
      chk("t2_b0", 64'({log_q[0].addr, log_q[0].len}), 64'({32'h0FC0, 8'd0}));
      chk("t2_b1", 64'({log_q[1].addr, log_q[1].len}), 64'({32'h1000, 8'd8}));
    end
    drain("t2_drain");

    // Credit stall: 320 beats with 256 credits and no returns.
    log_q.delete();
    issue(3, 32'h40000, 320);
    step();
    repeat (30) step();
    chk("t4_stalled_count", 64'(log_q.size()), 64'(4));
    chk("t4_busy", 64'(ch_busy[3]), 64'(1));
    r = 0;
    for (int k = 0; k < 64; k++) begin
      credit_ret[3] = 1'b1;
      owed[3]--;
      r = cyc;
      step();
    end
    wait_log("t4_resume", 5, 10);
    if (log_q.size() >= 5) chk("t4_resume_cycle", 64'(log_q[4].cyc - r), 64'(2));
    drain("t4_drain");

    // Round-robin from a fresh reset, then from rr=3.
    do_reset();
    arready = 1'b1;
    issue(0, 32'h10000, 64); issue(2, 32'h20000, 64); issue(5, 32'h30000, 64);
    step();
    wait_log("t3_a", 3, 20);
    if (log_q.size() >= 3)
      chk("t3_order_a", 64'({log_q[0].id[3:0], log_q[1].id[3:0], log_q[2].id[3:0]}), 64'(12'h025));
    drain("t3_a_drain");
    do_reset();
    arready = 1'b1;
    issue(2, 32'h8000, 64);
    step();
    wait_log("t3_prime", 1, 20);
    drain("t3_prime_drain");
    log_q.delete();
    issue(0, 32'h10000, 64); issue(2, 32'h20000, 64); issue(5, 32'h30000, 64);
    step();
    wait_log("t3_b", 3, 20);
    if (log_q.size() >= 3)
      chk("t3_order_b", 64'({log_q[0].id[3:0], log_q[1].id[3:0], log_q[2].id[3:0]}), 64'(12'h502));
    drain("t3_b_drain");

    // AR held stable under backpressure, then async reset mid-hold.
    arready = 1'b0;
    issue(1, 32'h5000, 16);
    step();
    r = 0;
    while (!arvalid && r < 10) begin step(); r++; end
    for (int k = 0; k < 10; k++) begin
      chk("hold_ar", 64'({arvalid, arid, arlen, araddr}), 64'({1'b1, 4'd1, 8'd15, 32'h5000}));
      step();
    end
    do_reset();

    // Credit return with a full counter, then a zero-length command.
    credit_ret[4] = 1'b1;
    step();
    step();
    chk("err_flag", 64'(credit_err), 64'(8'h10));
    chk("err_credit_unchanged", 64'(all_idle), 64'(1));
    log_q.delete();
    issue(6, 32'h9000, 0);
    step();
    repeat (10) step();
    chk("zero_no_ar", 64'(log_q.size()), 64'(0));
    chk("zero_idle", 64'({cmd_ready[6], ch_busy[6], all_idle}), 64'(3'b101));

    // Randomized traffic.
    for (int rnd = 0; rnd < 3; rnd++) begin
      rand_ardy = 1'b1; auto_ret = 1'b1;
      ret_pct = 20 + 30 * rnd;
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < N; i++)
          if (!cmd_valid[i] && $urandom_range(99) < 10)
            issue(i, $urandom & 32'h3fff_ffff, int'($urandom_range(300)));
        step();
      end
      while (cmd_valid != '0) step();
      drain("rand_drain");
    end
    chk("err_sticky_only", 64'(credit_err), 64'(8'h10));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mm2s_rd_scheduler.md
Name: mm2s_rd_scheduler

Overview:
- Credit-aware AXI read-address scheduler that feeds the multi-channel MM2S read datapath.
- Accepts one read command (beat-aligned address, beat count) per channel and splits it into INCR bursts that never cross a 4 KB boundary.
- Arbitrates between channels round-robin onto a single AR channel; channel index is used as ARID.
- A burst is issued only when the target channel's downstream FIFO has room reserved for every beat, so one stalled channel never blocks R data for the others.

Parameters:
- MEM_WIDTH, 512, data bus width in bits; must be a power of two ≥ 8.
- ADDR_WIDTH, 64, AXI address width.
- N_CHANNELS, 16, number of channels, 1..16; ARID is 4 bits.
- FIFO_DEPTH, 512, per-channel downstream FIFO depth in beats; initial credit; must be ≥ BURST_LEN.
- Derived: ARSIZE = clog2(MEM_WIDTH/8); BURST_LEN = 4096/(MEM_WIDTH/8), capped at 256; LEN_WIDTH = ADDR_WIDTH-ARSIZE; CW = clog2(FIFO_DEPTH+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  N_CHANNELS  per-channel command valid.
- cmd_ready  out  N_CHANNELS  per-channel command ready (channel idle).
- cmd_addr  in  ADDR_WIDTH x N_CHANNELS  byte address; low ARSIZE bits ignored.
- cmd_beats  in  LEN_WIDTH x N_CHANNELS  transfer length in beats.
- m_axi_araddr  out  ADDR_WIDTH  burst address, low ARSIZE bits zero.
- m_axi_arlen  out  8  beats-1.
- m_axi_arsize  out  3  constant ARSIZE.
- m_axi_arburst  out  2  constant 2'b01.
- m_axi_arcache  out  4  constant 4'b0011.
- m_axi_arprot  out  3  constant 3'b000.
- m_axi_arid  out  4  channel index.
- m_axi_arvalid  out  1  address valid.
- m_axi_arready  in  1  address ready.
- credit_ret  in  N_CHANNELS  one-cycle pulse per beat popped from that channel's FIFO.
- ch_busy  out  N_CHANNELS  channel holds unissued beats.
- all_idle  out  1  no busy channel, no AR pending, all credits full.
- credit_err  out  N_CHANNELS  sticky credit-overflow flag.

Behaviour:
- Reset (asynchronous on rst_n low, effective immediately, including mid-burst): arvalid=0; araddr/arlen/arid=0; cmd_ready=all 1; ch_busy=0; credit_err=0; credits=FIFO_DEPTH; rr pointer=0; all_idle=1. Unfinished commands are discarded.
- Per-channel FSM, IDLE/ACTIVE:
  - IDLE: cmd_ready=1. On cmd_valid, latch addr[ADDR_WIDTH-1:ARSIZE] and beats.
  - beats==0: accept and stay IDLE; no AR issued.
  - beats>0: go ACTIVE. ACTIVE → IDLE on the edge at which its last burst is loaded into the AR register.
- Burst size: b = min(remaining, BURST_LEN - (addr_beat mod BURST_LEN)), so no burst crosses 4 KB. arlen=b-1.
- At each burst load: addr_beat += b and remaining -= b, with LEN_WIDTH wrap-around (no saturation).
- Eligibility: channel ACTIVE and credit ≥ b.
- Arbitration:
  - Combinational over eligible channels, searching from rr pointer upward and wrapping.
  - Evaluated whenever the AR register is empty, or arvalid&&arready this cycle. Back-to-back bursts therefore need no bubble.
  - Grant loads the AR register at the next edge and sets rr pointer = grant+1 mod N.
- AR register: once arvalid=1, araddr/arlen/arid are held stable until arready. There is no combinational path from arready to arvalid.
- Latency: cmd handshake at edge E0 → earliest arvalid=1 after edge E1.
- Credits:
  - At load: credit -= b.
  - Per credit_ret pulse: credit += 1.
  - Same-cycle load and return: net update.
  - Return while credit==FIFO_DEPTH: ignored, credit_err[i] set (cleared only by reset).
- Channels with insufficient credit are skipped, not waited on; other channels continue.
- ch_busy[i] = ACTIVE[i].

Optional Feature:
- Macro MM2S_RD_SCHED_STATS_EN.
- Defined: adds output stat_bursts (32 x N_CHANNELS) and stat_stall_cycles (32). stat_bursts[i] increments per AR handshake with arid=i. stat_stall_cycles increments each cycle where some channel is ACTIVE but none is eligible. Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Ch0 cmd addr=0x0, beats=200, arready=1, credits full → bursts (0x0,len63),(0x1000,63),(0x2000,63),(0x3000,7) on consecutive cycles, arid=0; then cmd_ready[0]=1, all_idle=1 after 200 credit_ret pulses.
- Ch1 addr=0x0FC0, beats=10 → bursts (0x0FC0,len0),(0x1000,len8); no 4 KB crossing.
- Ch0,2,5 each beats=64 at once, arready=1 → arid order 0,2,5; repeat with rr=3 after reset gives 5,0,2 (verify rotation from grant+1).
- FIFO_DEPTH=64, ch3 beats=128, no credit_ret → one burst then stall, stat_stall_cycles counts; 64 credit_ret pulses → second burst issues next eligible cycle.
- Hold arready=0 for 10 cycles with arvalid=1 → araddr/arlen/arid stable; rst_n low mid-hold → arvalid=0 asynchronously, credits back to FIFO_DEPTH.
- credit_ret[4] pulse with credit full → credit_err[4]=1, credit unchanged; beats=0 command → accepted, no AR.
